// File: rtl/systolic_result_collector_if.sv
// Control, skewed-accumulator and row-output bundle for systolic_result_collector.
// master = the side driving start/accumulators/out_ready; slave = the collector.
interface systolic_result_collector_if #(
    parameter int unsigned ACC_W = 32,
    parameter int unsigned CNT_W = 8,
    parameter int unsigned DEPTH = 4
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic             start;
    logic [CNT_W-1:0] num_rows;
    logic             acc_valid;
    logic [ACC_W-1:0] acc_in1;
    logic [ACC_W-1:0] acc_in2;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_data1;
    logic [ACC_W-1:0] out_data2;
    logic [CW-1:0]    fifo_count;
    logic             busy;
    logic             done;
    logic             overflow;

    modport master (
        output start, num_rows, acc_valid, acc_in1, acc_in2, out_ready,
        input  out_valid, out_data1, out_data2, fifo_count, busy, done, overflow
    );

    modport slave (
        input  start, num_rows, acc_valid, acc_in1, acc_in2, out_ready,
        output out_valid, out_data1, out_data2, fifo_count, busy, done, overflow
    );
endinterface

// File: rtl/systolic_result_collector.sv
// Re-aligns column-skewed 2x2 systolic accumulator outputs into rows, buffers them, streams them out.
// Build macro COLLECTOR_SAT16_EN: clamp each column to signed 16-bit before buffering.
module systolic_result_collector #(
    parameter int unsigned ACC_W    = 32,
    parameter int unsigned COL_SKEW = 1,
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned CNT_W    = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    systolic_result_collector_if.slave bus
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_DRAIN, S_DONE} state_e;
    typedef struct packed {
        logic [ACC_W-1:0] c0;
        logic [ACC_W-1:0] c1;
    } row_t;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    num_rows_q, issued_q, completed_q;
    logic [COL_SKEW-1:0] dl_vld_q;
    logic [ACC_W-1:0]    dl_data_q [COL_SKEW];
    row_t                mem_q [DEPTH];
    logic [PW-1:0]       wr_ptr_q, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]       count_q, count_d;
    row_t                out_row_q, head_d, row_c;
    logic                out_valid_q, busy_q, busy_d, done_q, done_d, overflow_q;
    logic                start_ok, capture, form, pop, full, push, drop;

`ifdef COLLECTOR_SAT16_EN
    localparam logic [ACC_W-1:0] SAT_MAX = ACC_W'(32'sd32767);
    localparam logic [ACC_W-1:0] SAT_MIN = ACC_W'(-32'sd32768);
`endif

    function automatic logic [ACC_W-1:0] col_fmt(input logic [ACC_W-1:0] v);
`ifdef COLLECTOR_SAT16_EN
        if ($signed(v) > $signed(SAT_MAX)) return SAT_MAX;
        if ($signed(v) < $signed(SAT_MIN)) return SAT_MIN;
        return v;
`else
        return v;
`endif
    endfunction

    // FSM state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (bus.start) state_d = (bus.num_rows == '0) ? S_DONE : S_COLLECT;
            S_COLLECT: if (completed_q == num_rows_q) state_d = S_DRAIN;
            S_DRAIN:   if (count_q == '0) state_d = S_DONE;
            S_DONE:    state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // FSM outputs; done trails the DONE state by one cycle
    always_comb begin
        busy_d = (state_d != S_IDLE);
        done_d = (state_q == S_DONE);
    end

    // Capture, alignment and FIFO control
    always_comb begin
        start_ok = (state_q == S_IDLE) && bus.start;
        capture  = (state_q == S_COLLECT) && bus.acc_valid && (issued_q < num_rows_q);
        form     = dl_vld_q[COL_SKEW-1];
        row_c.c0 = col_fmt(dl_data_q[COL_SKEW-1]);
        row_c.c1 = col_fmt(bus.acc_in2);
        pop      = out_valid_q && bus.out_ready;
        full     = (count_q == CW'(DEPTH));
        push     = form && (!full || pop);
        drop     = form && !push;
        rd_ptr_d = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
        count_d  = count_q;
        if (push && !pop)      count_d = count_q + CW'(1);
        else if (pop && !push) count_d = count_q - CW'(1);
        // A row written into the slot that becomes the head must bypass the storage read
        head_d = mem_q[rd_ptr_d];
        if (push && (wr_ptr_q == rd_ptr_d)) head_d = row_c;
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= row_c;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            num_rows_q  <= '0;
            issued_q    <= '0;
            completed_q <= '0;
            dl_vld_q    <= '0;
            for (int i = 0; i < COL_SKEW; i++) dl_data_q[i] <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            out_valid_q <= 1'b0;
            out_row_q   <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            dl_vld_q[0]  <= capture;
            dl_data_q[0] <= bus.acc_in1;
            for (int i = 1; i < COL_SKEW; i++) begin
                dl_vld_q[i]  <= dl_vld_q[i-1];
                dl_data_q[i] <= dl_data_q[i-1];
            end
            if (start_ok) begin
                num_rows_q  <= bus.num_rows;
                issued_q    <= '0;
                completed_q <= '0;
                overflow_q  <= 1'b0;
            end else begin
                if (capture) issued_q    <= issued_q + CNT_W'(1);
                if (form)    completed_q <= completed_q + CNT_W'(1);
                if (drop)    overflow_q  <= 1'b1;
            end
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            out_valid_q <= (count_d != '0);
            out_row_q   <= head_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign bus.out_valid  = out_valid_q;
    assign bus.out_data1  = out_row_q.c0;
    assign bus.out_data2  = out_row_q.c1;
    assign bus.fifo_count = count_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.overflow   = overflow_q;
endmodule

// File: tb/tb_systolic_result_collector.sv
// Self-checking bench for systolic_result_collector: vector table plus hand-written multi-cycle sequences.
module tb_systolic_result_collector;
    localparam int unsigned ACC_W = 32;
    localparam int unsigned SKEW  = 1;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned CNT_W = 8;
`ifdef COLLECTOR_SAT16_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] d1;
        logic [31:0] d2;
    } row_t;

    typedef struct {
        logic [31:0] a1;
        logic [31:0] a2;
        logic [31:0] e1;
        logic [31:0] e2;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;
    row_t exp_q[$];
    vec_t tbl[6];

    always #5 clk = ~clk;

    systolic_result_collector_if #(.ACC_W(ACC_W), .CNT_W(CNT_W), .DEPTH(DEPTH)) bus ();

    systolic_result_collector #(
        .ACC_W(ACC_W), .COL_SKEW(SKEW), .DEPTH(DEPTH), .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    function automatic logic [31:0] model(input logic [31:0] v);
        if (!SAT) return v;
        if ($signed(v) > 32'sd32767)  return 32'h0000_7FFF;
        if ($signed(v) < -32'sd32768) return 32'hFFFF_8000;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Every accepted row is compared against the scoreboard head
    always @(negedge clk) begin
        if (reset && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_row: got %h/%h want none", bus.out_data1, bus.out_data2);
            end else begin
                row_t e;
                e = exp_q.pop_front();
                check("row_d1", bus.out_data1, e.d1);
                check("row_d2", bus.out_data2, e.d2);
            end
        end
    end

    task automatic start_pass(input int rows);
        bus.num_rows = CNT_W'(rows);
        bus.start    = 1'b1;
        tick();
        bus.start    = 1'b0;
    endtask

    // n capture cycles, first 'keep' rows expected; col1 trails col0 by SKEW cycles
    task automatic stream(input int n, input int keep, input logic [31:0] b1, input logic [31:0] b2);
        for (int k = 0; k < n + int'(SKEW); k++) begin
            bus.acc_valid = (k < n);
            bus.acc_in1   = (k < n) ? b1 + 32'(k) : 32'h0;
            bus.acc_in2   = (k >= int'(SKEW)) ? b2 + 32'(10 * (k - int'(SKEW))) : 32'h0;
            if (k < keep) exp_q.push_back('{model(b1 + 32'(k)), model(b2 + 32'(10 * k))});
            tick();
        end
        bus.acc_valid = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (bus.done !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(bus.done), 32'd1);
        check("busy_fall", 32'(bus.busy), 32'd0);
        @(negedge clk);
        check("done_pulse", 32'(bus.done), 32'd0);
    endtask

    task automatic single_row(input logic [31:0] a1, input logic [31:0] a2,
                              input logic [31:0] e1, input logic [31:0] e2);
        start_pass(1);
        bus.acc_valid = 1'b1;
        bus.acc_in1   = a1;
        exp_q.push_back('{e1, e2});
        tick();
        check("row_early", 32'(bus.out_valid), 32'd0);
        bus.acc_valid = 1'b0;
        bus.acc_in2   = a2;
        tick();
        @(negedge clk);
        check("row_latency", 32'(bus.out_valid), 32'd1);
        check("row_head_d1", bus.out_data1, e1);
        check("row_head_d2", bus.out_data2, e2);
        wait_done("row_done");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{32'h0000_0005, 32'h0000_0007, 32'h0000_0005, 32'h0000_0007};
        tbl[1] = '{32'hFFFF_FFFF, 32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0000};
        tbl[2] = '{32'h0001_2345, 32'hFFFE_0000,
                   SAT ? 32'h0000_7FFF : 32'h0001_2345, SAT ? 32'hFFFF_8000 : 32'hFFFE_0000};
        tbl[3] = '{32'h0000_7FFF, 32'hFFFF_8000, 32'h0000_7FFF, 32'hFFFF_8000};
        tbl[4] = '{32'h0000_8000, 32'hFFFF_7FFF,
                   SAT ? 32'h0000_7FFF : 32'h0000_8000, SAT ? 32'hFFFF_8000 : 32'hFFFF_7FFF};
        tbl[5] = '{32'h7FFF_FFFF, 32'h8000_0000,
                   SAT ? 32'h0000_7FFF : 32'h7FFF_FFFF, SAT ? 32'hFFFF_8000 : 32'h8000_0000};

        reset         = 1'b0;
        bus.start     = 1'b0;
        bus.num_rows  = '0;
        bus.acc_valid = 1'b0;
        bus.acc_in1   = '0;
        bus.acc_in2   = '0;
        bus.out_ready = 1'b1;
        #12;
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_count", 32'(bus.fifo_count), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_overflow", 32'(bus.overflow), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        tick();

        for (int i = 0; i < 6; i++) single_row(tbl[i].a1, tbl[i].a2, tbl[i].e1, tbl[i].e2);

        // Streaming, back-to-back captures
        tick();
        start_pass(4);
        stream(4, 4, 32'd1, 32'd10);
        wait_done("stream_done");
        check("stream_ovf", 32'(bus.overflow), 32'd0);

        // Overflow: six rows into a four-deep FIFO with no consumer
        tick();
        bus.out_ready = 1'b0;
        start_pass(6);
        stream(6, 4, 32'd100, 32'd1000);
        @(negedge clk);
        check("ovf_count", 32'(bus.fifo_count), 32'd4);
        check("ovf_flag", 32'(bus.overflow), 32'd1);
        check("ovf_busy", 32'(bus.busy), 32'd1);
        tick();
        bus.out_ready = 1'b1;
        wait_done("ovf_done");
        check("ovf_sticky", 32'(bus.overflow), 32'd1);

        // Full FIFO accepts a row when a pop happens in the same cycle
        tick();
        bus.out_ready = 1'b0;
        start_pass(5);
        @(negedge clk);
        check("ovf_cleared", 32'(bus.overflow), 32'd0);
        stream(4, 4, 32'd200, 32'd2000);
        @(negedge clk);
        check("full_count", 32'(bus.fifo_count), 32'd4);
        tick();
        bus.acc_valid = 1'b1;
        bus.acc_in1   = 32'h55;
        exp_q.push_back('{model(32'h55), model(32'h5555)});
        tick();
        bus.acc_valid = 1'b0;
        bus.acc_in2   = 32'h5555;
        bus.out_ready = 1'b1;
        tick();
        @(negedge clk);
        check("pushpop_count", 32'(bus.fifo_count), 32'd4);
        check("pushpop_ovf", 32'(bus.overflow), 32'd0);
        wait_done("pushpop_done");

        // Zero-row pass: done two cycles after start
        tick();
        start_pass(0);
        @(negedge clk);
        check("zero_busy", 32'(bus.busy), 32'd1);
        check("zero_early", 32'(bus.done), 32'd0);
        @(negedge clk);
        check("zero_done", 32'(bus.done), 32'd1);
        @(negedge clk);
        check("zero_pulse", 32'(bus.done), 32'd0);
        check("zero_idle", 32'(bus.busy), 32'd0);

        // acc_valid while idle is not captured
        tick();
        bus.acc_valid = 1'b1;
        bus.acc_in1   = 32'hDEAD;
        repeat (3) tick();
        bus.acc_valid = 1'b0;
        bus.acc_in2   = 32'hBEEF;
        tick();
        @(negedge clk);
        check("idle_count", 32'(bus.fifo_count), 32'd0);
        check("idle_valid", 32'(bus.out_valid), 32'd0);

        // Restart ignored mid-pass; captures beyond num_rows ignored
        tick();
        start_pass(2);
        bus.start    = 1'b1;
        bus.num_rows = CNT_W'(1);
        tick();
        bus.start    = 1'b0;
        stream(4, 2, 32'd300, 32'd3000);
        wait_done("extra_done");
        check("extra_ovf", 32'(bus.overflow), 32'd0);
        check("extra_count", 32'(bus.fifo_count), 32'd0);

        // Reset in the middle of a pass
        tick();
        bus.out_ready = 1'b0;
        start_pass(4);
        stream(2, 2, 32'd400, 32'd4000);
        @(negedge clk);
        check("pre_rst_count", 32'(bus.fifo_count), 32'd2);
        #2;
        reset = 1'b0;
        #1;
        check("mid_rst_valid", 32'(bus.out_valid), 32'd0);
        check("mid_rst_count", 32'(bus.fifo_count), 32'd0);
        check("mid_rst_busy", 32'(bus.busy), 32'd0);
        check("mid_rst_done", 32'(bus.done), 32'd0);
        check("mid_rst_ovf", 32'(bus.overflow), 32'd0);
        check("mid_rst_d1", bus.out_data1, 32'd0);
        check("mid_rst_d2", bus.out_data2, 32'd0);
        exp_q.delete();
        @(negedge clk);
        reset         = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        single_row(32'd9, 32'd11, 32'd9, 32'd11);

        repeat (3) tick();
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
